rocc_accum_bank: RTL

//  Parametrised RoCC accumulator accelerator: a bank of NUM_ACC xLen-bit accumulators.

---
 rtl/rocc_accum_pkg.sv | 19 +
 rtl/rocc_acc_regfile.sv | 33 +++
 rtl/rocc_accum_bank.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rocc_accum_pkg.sv
// Shared encodings for the RoCC accumulator bank: funct codes, FSM states
// and the D$ read command.
package rocc_accum_pkg;

    localparam logic [6:0] FN_WRITE = 7'd0;
    localparam logic [6:0] FN_READ  = 7'd1;
    localparam logic [6:0] FN_ADD   = 7'd2;
    localparam logic [6:0] FN_LOAD  = 7'd3;

    localparam int M_XRD = 0;

    typedef enum logic [1:0] {
        IDLE,
        MREQ,
        MWAIT,
        RESP
    } state_e;

endpackage

// File: rtl/rocc_acc_regfile.sv
// Accumulator storage: NUM_ACC words of XLEN bits, one asynchronous read
// port and one synchronous write port, cleared by reset.
module rocc_acc_regfile #(
    parameter int XLEN    = 64,
    parameter int NUM_ACC = 4,
    parameter int IDX_W   = $clog2(NUM_ACC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] raddr,
    output logic [XLEN-1:0]  rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata
);

    logic [XLEN-1:0] acc_q [NUM_ACC];

    // NOTE: the accumulators are software-visible state, so the whole array is
    // reset here rather than only the control path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_q[i] <= '0;
            end
        end else if (we) begin
            acc_q[waddr] <= wdata;
        end
    end

    assign rdata = acc_q[raddr];

endmodule

// File: rtl/rocc_accum_bank.sv
// RoCC accumulator accelerator: command decode, the single-outstanding D$
// load path with nack retry, and a held response toward the core.
module rocc_accum_bank
    import rocc_accum_pkg::*;
#(
    parameter int xLen             = 64,
    parameter int NUM_ACC          = 4,
    parameter int coreMaxAddrBits  = 40,
    parameter int dcacheReqTagBits = 9,
    parameter int M_SZ             = 5
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        rocc_cmd_ready,
    input  logic                        rocc_cmd_valid,
    input  logic [6:0]                  rocc_cmd_bits_inst_funct,
    input  logic [4:0]                  rocc_cmd_bits_inst_rd,
    input  logic                        rocc_cmd_bits_inst_xd,
    input  logic [xLen-1:0]             rocc_cmd_bits_rs1,
    input  logic [xLen-1:0]             rocc_cmd_bits_rs2,
    input  logic                        rocc_resp_ready,
    output logic                        rocc_resp_valid,
    output logic [4:0]                  rocc_resp_bits_rd,
    output logic [xLen-1:0]             rocc_resp_bits_data,
    input  logic                        rocc_mem_req_ready,
    output logic                        rocc_mem_req_valid,
    output logic [coreMaxAddrBits-1:0]  rocc_mem_req_bits_addr,
    output logic [dcacheReqTagBits-1:0] rocc_mem_req_bits_tag,
    output logic [M_SZ-1:0]             rocc_mem_req_bits_cmd,
    output logic [1:0]                  rocc_mem_req_bits_size,
    input  logic                        rocc_mem_s2_nack,
    input  logic                        rocc_mem_resp_valid,
    input  logic [xLen-1:0]             rocc_mem_resp_bits_data,
    output logic                        rocc_busy,
    output logic                        rocc_interrupt
);

    localparam int IDX_W     = $clog2(NUM_ACC);
    localparam int SIZE_LOG2 = $clog2(xLen / 8);

    state_e                     state_q;
    logic [4:0]                 rd_q;
    logic                       xd_q;
    logic [IDX_W-1:0]           idx_q;
    logic [coreMaxAddrBits-1:0] addr_q;
    logic [xLen-1:0]            resp_data_q;

    logic                       cmd_fire;
    logic                       mem_done;
    logic [IDX_W-1:0]           acc_idx;
    logic [xLen-1:0]            acc_rdata;
    logic [xLen-1:0]            add_operand;
    logic [xLen-1:0]            acc_sum;
    logic                       acc_we;
    logic [xLen-1:0]            acc_wdata;
    logic [xLen-1:0]            result;
    logic                       unused_rs2;

    assign cmd_fire = rocc_cmd_valid && (state_q == IDLE);
    // A nack in the same cycle as resp_valid means the data is not real.
    assign mem_done = (state_q == MWAIT) && !rocc_mem_s2_nack && rocc_mem_resp_valid;

    // One read port and one adder serve both the command cycle and the load return.
    assign acc_idx     = (state_q == IDLE) ? rocc_cmd_bits_rs2[IDX_W-1:0] : idx_q;
    assign add_operand = (state_q == MWAIT) ? rocc_mem_resp_bits_data : rocc_cmd_bits_rs1;
    assign acc_sum     = acc_rdata + add_operand;
    assign unused_rs2  = ^rocc_cmd_bits_rs2[xLen-1:IDX_W];

    rocc_acc_regfile #(
        .XLEN    (xLen),
        .NUM_ACC (NUM_ACC)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .raddr (acc_idx),
        .rdata (acc_rdata),
        .we    (acc_we),
        .waddr (acc_idx),
        .wdata (acc_wdata)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case can hold a value and infer a latch.
    always_comb begin
        acc_we    = 1'b0;
        acc_wdata = acc_sum;
        result    = '0;
        if (cmd_fire) begin
            case (rocc_cmd_bits_inst_funct)
                FN_WRITE: begin
                    acc_we    = 1'b1;
                    acc_wdata = rocc_cmd_bits_rs1;
                    result    = acc_rdata;
                end
                FN_READ: result = acc_rdata;
                FN_ADD: begin
                    acc_we = 1'b1;
                    result = acc_sum;
                end
                default: result = '0;
            endcase
        end else if (mem_done) begin
            acc_we = 1'b1;
            result = acc_sum;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            xd_q        <= 1'b0;
            idx_q       <= '0;
            addr_q      <= '0;
            resp_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        rd_q        <= rocc_cmd_bits_inst_rd;
                        xd_q        <= rocc_cmd_bits_inst_xd;
                        idx_q       <= rocc_cmd_bits_rs2[IDX_W-1:0];
                        addr_q      <= coreMaxAddrBits'(rocc_cmd_bits_rs1);
                        resp_data_q <= result;
                        if (rocc_cmd_bits_inst_funct == FN_LOAD) begin
                            state_q <= MREQ;
                        end else begin
                            state_q <= rocc_cmd_bits_inst_xd ? RESP : IDLE;
                        end
                    end
                end
                MREQ: begin
                    if (rocc_mem_req_ready) begin
                        state_q <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (rocc_mem_s2_nack) begin
                        state_q <= MREQ;
                    end else if (mem_done) begin
                        resp_data_q <= result;
                        state_q     <= xd_q ? RESP : IDLE;
                    end
                end
                RESP: begin
                    if (rocc_resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rocc_cmd_ready         = (state_q == IDLE);
    assign rocc_resp_valid        = (state_q == RESP);
    assign rocc_resp_bits_rd      = rd_q;
    assign rocc_resp_bits_data    = resp_data_q;
    assign rocc_mem_req_valid     = (state_q == MREQ);
    assign rocc_mem_req_bits_addr = addr_q;
    assign rocc_mem_req_bits_tag  = '0;
    assign rocc_mem_req_bits_cmd  = M_SZ'(M_XRD);
    assign rocc_mem_req_bits_size = 2'(SIZE_LOG2);
    assign rocc_busy              = (state_q != IDLE);
    assign rocc_interrupt         = 1'b0;

endmodule
